// File: rtl/gmii_tx_framer.sv
// Host byte stream to GMII: preamble/SFD, payload, underrun abort, inter-frame gap.
// Define GMII_TX_FRAMER_FCS_EN to add minimum-length zero padding and the CRC-32 FCS.
module gmii_tx_framer #(
    parameter int IFG_BYTES = 12,
    parameter int MIN_BYTES = 60
) (
    input  logic        gmii_clk,
    input  logic        rst_n,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    input  logic        tx_last,
    output logic        tx_ready,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [7:0]  underrun_cnt
);

`ifdef GMII_TX_FRAMER_FCS_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, PRE = 3'd1, SFD = 3'd2, DATA = 3'd3,
        PAD = 3'd4, FCS = 3'd5, DRAIN = 3'd6, IFG = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, PRE = 3'd1, SFD = 3'd2, DATA = 3'd3,
        DRAIN = 3'd6, IFG = 3'd7
    } state_t;
`endif

    localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);

    state_t      state, state_nx;
    logic [7:0]  cyc_cnt, cyc_cnt_nx;
    logic [7:0]  txd_nx;
    logic        en_nx, er_nx, frame_inc, underrun_inc;

`ifdef GMII_TX_FRAMER_FCS_EN
    localparam logic [10:0] MIN_CNT = 11'(MIN_BYTES);

    logic [10:0] byte_cnt, byte_cnt_nx, cnt_inc;
    logic [31:0] crc, crc_nx, fcs;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB8_8320 : 32'h0);
        return r;
    endfunction

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    assign cnt_inc = sat_inc(byte_cnt);
    assign fcs     = ~crc;
`endif

    assign tx_ready = (state == SFD) || (state == DATA) || (state == DRAIN);
    assign busy     = (state != IDLE);

    // Next-state logic computes the byte driven on GMII in the following cycle.
    always_comb begin
        state_nx     = state;
        cyc_cnt_nx   = cyc_cnt;
        txd_nx       = 8'h00;
        en_nx        = 1'b0;
        er_nx        = 1'b0;
        frame_inc    = 1'b0;
        underrun_inc = 1'b0;
`ifdef GMII_TX_FRAMER_FCS_EN
        byte_cnt_nx  = byte_cnt;
        crc_nx       = crc;
`endif
        unique case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_nx   = PRE;
                    cyc_cnt_nx = 8'd0;
                    txd_nx     = 8'h55;
                    en_nx      = 1'b1;
`ifdef GMII_TX_FRAMER_FCS_EN
                    byte_cnt_nx = 11'd0;
                    crc_nx      = 32'hFFFF_FFFF;
`endif
                end
            end
            PRE: begin
                en_nx      = 1'b1;
                cyc_cnt_nx = cyc_cnt + 8'd1;
                if (cyc_cnt == 8'd6) begin
                    state_nx = SFD;
                    txd_nx   = 8'hD5;
                end else begin
                    txd_nx   = 8'h55;
                end
            end
            // The preamble is already on the wire during SFD, so a missing first byte
            // is as fatal as a gap later on and is treated as an underrun too.
            SFD, DATA: begin
                en_nx = 1'b1;
                if (tx_valid) begin
                    txd_nx   = tx_data;
                    state_nx = DATA;
`ifdef GMII_TX_FRAMER_FCS_EN
                    byte_cnt_nx = cnt_inc;
                    crc_nx      = crc32_byte(crc, tx_data);
                    if (tx_last) begin
                        state_nx   = (cnt_inc < MIN_CNT) ? PAD : FCS;
                        cyc_cnt_nx = 8'd0;
                    end
`else
                    if (tx_last) begin
                        state_nx   = IFG;
                        cyc_cnt_nx = 8'd0;
                        frame_inc  = 1'b1;
                    end
`endif
                end else begin
                    txd_nx       = 8'hFF;
                    er_nx        = 1'b1;
                    underrun_inc = 1'b1;
                    state_nx     = DRAIN;
                end
            end
`ifdef GMII_TX_FRAMER_FCS_EN
            PAD: begin
                en_nx       = 1'b1;
                byte_cnt_nx = cnt_inc;
                crc_nx      = crc32_byte(crc, 8'h00);
                if (cnt_inc >= MIN_CNT) begin
                    state_nx   = FCS;
                    cyc_cnt_nx = 8'd0;
                end
            end
            FCS: begin
                en_nx      = 1'b1;
                txd_nx     = fcs[{cyc_cnt[1:0], 3'b000} +: 8];
                cyc_cnt_nx = cyc_cnt + 8'd1;
                if (cyc_cnt == 8'd3) begin
                    state_nx   = IFG;
                    cyc_cnt_nx = 8'd0;
                    frame_inc  = 1'b1;
                end
            end
`endif
            DRAIN: begin
                if (tx_valid && tx_last) begin
                    state_nx   = IFG;
                    cyc_cnt_nx = 8'd0;
                end
            end
            IFG: begin
                cyc_cnt_nx = cyc_cnt + 8'd1;
                if (cyc_cnt == IFG_LAST)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge gmii_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cyc_cnt      <= 8'd0;
            gmii_txd     <= 8'h00;
            gmii_tx_en   <= 1'b0;
            gmii_tx_er   <= 1'b0;
            frame_cnt    <= 16'd0;
            underrun_cnt <= 8'd0;
        end else begin
            state      <= state_nx;
            cyc_cnt    <= cyc_cnt_nx;
            gmii_txd   <= txd_nx;
            gmii_tx_en <= en_nx;
            gmii_tx_er <= er_nx;
            if (frame_inc)
                frame_cnt <= frame_cnt + 16'd1;
            if (underrun_inc && (underrun_cnt != 8'hFF))
                underrun_cnt <= underrun_cnt + 8'd1;
        end
    end

`ifdef GMII_TX_FRAMER_FCS_EN
    always_ff @(posedge gmii_clk) begin
        byte_cnt <= byte_cnt_nx;
        crc      <= crc_nx;
    end
`endif

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Scoreboard bench for gmii_tx_framer; follows GMII_TX_FRAMER_FCS_EN like the design.
`timescale 1ns/1ps
module tb_gmii_tx_framer;
    localparam int IFG  = 12;
    localparam int MINB = 60;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_last = 1'b0;
    logic        tx_ready;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en, gmii_tx_er, busy;
    logic [15:0] frame_cnt;
    logic [7:0]  underrun_cnt;

    gmii_tx_framer #(.IFG_BYTES(IFG), .MIN_BYTES(MINB)) dut (
        .gmii_clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_last(tx_last), .tx_ready(tx_ready), .gmii_txd(gmii_txd),
        .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er), .busy(busy),
        .frame_cnt(frame_cnt), .underrun_cnt(underrun_cnt)
    );

    always #4 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int exp_frames = 0, exp_underruns = 0;
    logic [8:0] exp_q[$];
    int gap_q[$];
    int run_len = 0, last_run = 0, gap_len = 0;
    logic [8:0] mon_e;

    // Monitor: every enabled GMII cycle is checked against the head of the scoreboard.
    always @(negedge clk) begin
        if (gmii_tx_en === 1'b1) begin
            if (run_len == 0) gap_q.push_back(gap_len);
            run_len++;
            gap_len = 0;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL gmii_byte: got er=%b txd=%02h, expected no transmission", gmii_tx_er, gmii_txd);
            end else begin
                mon_e = exp_q.pop_front();
                if ({gmii_tx_er, gmii_txd} !== mon_e) begin
                    n_bad++;
                    $display("FAIL gmii_byte: got er=%b txd=%02h, expected er=%b txd=%02h",
                             gmii_tx_er, gmii_txd, mon_e[8], mon_e[7:0]);
                end
            end
        end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
            gap_len++;
            if (gmii_tx_er !== 1'b0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL idle_er: got %b, expected 0", gmii_tx_er);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic fb;
        r = c;
        for (int k = 0; k < 8; k++) begin
            fb = r[31] ^ d[k];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ 32'h04C1_1DB7;
        end
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) r[k] = x[31-k];
        return r;
    endfunction

    function automatic int exp_run(input int len);
`ifdef GMII_TX_FRAMER_FCS_EN
        return 8 + ((len < MINB) ? MINB : len) + 4;
`else
        return 8 + len;
`endif
    endfunction

    // Drives one frame and pushes what must appear on GMII. Always entered and left
    // 1 ns after a rising edge.
    task automatic drive_frame(input int len, input int seed, input int drop_after,
                               input int abort_after, input bit keep_valid, output int start_lat);
        int i, cyc;
        bit acc, dropping, dropped;
        logic [31:0] c, f;
        c = 32'hFFFF_FFFF;
        start_lat = -1;
        dropping = 0;
        dropped = 0;
        for (int k = 0; k < 7; k++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        i = 0;
        cyc = 0;
        tx_valid = 1'b1;
        tx_data  = 8'(seed);
        tx_last  = (len == 1);
        while (i < len && cyc < 2000) begin
            acc = tx_valid && tx_ready;
            @(posedge clk); #1;
            cyc++;
            if (start_lat < 0 && gmii_tx_en === 1'b1) start_lat = cyc;
            if (dropping) begin
                dropping = 0;
                tx_valid = 1'b1;
            end else if (acc) begin
                if (!dropped) begin
                    exp_q.push_back({1'b0, tx_data});
                    c = crc_step(c, tx_data);
                end
                i++;
                if (abort_after >= 0 && i == abort_after) return;
                if (i == drop_after) begin
                    dropped  = 1;
                    dropping = 1;
                    tx_valid = 1'b0;
                    exp_q.push_back(9'h1FF);
                end
                tx_data = 8'(seed + i);
                tx_last = (i == len - 1);
            end
        end
        if (i < len) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drive_timeout: accepted %0d bytes, required %0d", i, len);
        end
`ifdef GMII_TX_FRAMER_FCS_EN
        if (!dropped) begin
            for (int k = len; k < MINB; k++) begin
                exp_q.push_back(9'h000);
                c = crc_step(c, 8'h00);
            end
            f = ~rev32(c);
            for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, f[8*k +: 8]});
        end
`else
        f = c;
`endif
        if (!keep_valid) begin
            tx_valid = 1'b0;
            tx_last  = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int cyc;
        cyc = 0;
        while ((busy !== 1'b0 || gmii_tx_en !== 1'b0) && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (busy !== 1'b0 || gmii_tx_en !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_idle_timeout: busy=%b en=%b after %0d cycles, required idle", tag, busy, gmii_tx_en, cyc);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp += 7;
        if (gmii_txd !== 8'h00)     begin n_bad++; $display("FAIL rst_txd: got %02h, expected 00", gmii_txd); end
        if (gmii_tx_en !== 1'b0)    begin n_bad++; $display("FAIL rst_en: got %b, expected 0", gmii_tx_en); end
        if (gmii_tx_er !== 1'b0)    begin n_bad++; $display("FAIL rst_er: got %b, expected 0", gmii_tx_er); end
        if (tx_ready !== 1'b0)      begin n_bad++; $display("FAIL rst_ready: got %b, expected 0", tx_ready); end
        if (busy !== 1'b0)          begin n_bad++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        if (frame_cnt !== 16'd0)    begin n_bad++; $display("FAIL rst_frame_cnt: got %0d, expected 0", frame_cnt); end
        if (underrun_cnt !== 8'd0)  begin n_bad++; $display("FAIL rst_underrun_cnt: got %0d, expected 0", underrun_cnt); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_frames();
        int lens[4]  = '{60, 64, 10, 1};
        int seeds[4] = '{0, 8'h40, 8'h80, 8'h5A};
        int lat;
        for (int t = 0; t < 4; t++) begin
            drive_frame(lens[t], seeds[t], -1, -1, 1'b0, lat);
            wait_idle("single");
            exp_frames++;
            n_cmp += 3;
            if (last_run != exp_run(lens[t])) begin
                n_bad++;
                $display("FAIL frame%0d_en_cycles: got %0d, expected %0d", lens[t], last_run, exp_run(lens[t]));
            end
            if (frame_cnt !== 16'(exp_frames)) begin
                n_bad++;
                $display("FAIL frame%0d_frame_cnt: got %0d, expected %0d", lens[t], frame_cnt, exp_frames);
            end
            if (exp_q.size() != 0) begin
                n_bad++;
                $display("FAIL frame%0d_missing_bytes: got %0d unsent, expected 0", lens[t], exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        gap_q.delete();
        for (int k = 0; k < 3; k++)
            drive_frame(64, 16 * k, -1, -1, (k < 2), lat);
        wait_idle("b2b");
        exp_frames += 3;
        n_cmp += 3;
        if (gap_q.size() != 3) begin
            n_bad++;
            $display("FAIL b2b_frames: got %0d frame starts, expected 3", gap_q.size());
        end else begin
            if (gap_q[1] != IFG) begin n_bad++; $display("FAIL b2b_gap1: got %0d, expected %0d", gap_q[1], IFG); end
            if (gap_q[2] != IFG) begin n_bad++; $display("FAIL b2b_gap2: got %0d, expected %0d", gap_q[2], IFG); end
        end
        n_cmp++;
        if (frame_cnt !== 16'(exp_frames)) begin
            n_bad++;
            $display("FAIL b2b_frame_cnt: got %0d, expected %0d", frame_cnt, exp_frames);
        end
    endtask

    task automatic test_underrun();
        int lat;
        drive_frame(100, 8'h10, 20, -1, 1'b0, lat);
        wait_idle("underrun");
        exp_underruns++;
        n_cmp += 4;
        if (underrun_cnt !== 8'(exp_underruns)) begin
            n_bad++;
            $display("FAIL underrun_cnt: got %0d, expected %0d", underrun_cnt, exp_underruns);
        end
        if (frame_cnt !== 16'(exp_frames)) begin
            n_bad++;
            $display("FAIL underrun_frame_cnt: got %0d, expected %0d", frame_cnt, exp_frames);
        end
        if (last_run != 29) begin
            n_bad++;
            $display("FAIL underrun_en_cycles: got %0d, expected 29", last_run);
        end
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL underrun_missing_bytes: got %0d unsent, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_frame();
        int lat;
        drive_frame(100, 8'h33, -1, 30, 1'b0, lat);
        rst_n = 1'b0;
        #1;
        n_cmp += 5;
        if (gmii_tx_en !== 1'b0)   begin n_bad++; $display("FAIL midrst_en: got %b, expected 0", gmii_tx_en); end
        if (gmii_tx_er !== 1'b0)   begin n_bad++; $display("FAIL midrst_er: got %b, expected 0", gmii_tx_er); end
        if (busy !== 1'b0)         begin n_bad++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
        if (frame_cnt !== 16'd0)   begin n_bad++; $display("FAIL midrst_frame_cnt: got %0d, expected 0", frame_cnt); end
        if (underrun_cnt !== 8'd0) begin n_bad++; $display("FAIL midrst_underrun_cnt: got %0d, expected 0", underrun_cnt); end
        exp_q.delete();
        exp_frames = 0;
        exp_underruns = 0;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive_frame(64, 8'hC0, -1, -1, 1'b0, lat);
        wait_idle("postrst");
        exp_frames++;
        n_cmp += 3;
        if (lat != 1) begin n_bad++; $display("FAIL postrst_start_latency: got %0d, expected 1", lat); end
        if (last_run != exp_run(64)) begin
            n_bad++;
            $display("FAIL postrst_en_cycles: got %0d, expected %0d", last_run, exp_run(64));
        end
        if (frame_cnt !== 16'(exp_frames)) begin
            n_bad++;
            $display("FAIL postrst_frame_cnt: got %0d, expected %0d", frame_cnt, exp_frames);
        end
    endtask

    initial begin
        test_reset();
        test_single_frames();
        test_back_to_back();
        test_underrun();
        test_reset_mid_frame();
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL final_scoreboard: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
